// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
// Holds the op encoding, FSM states and small two's-complement helpers.
package ex_muldiv_unit_pkg;

   localparam int DATA_W    = 32;
   localparam int DIV_STEPS = 32;
   localparam int CNT_W     = 5;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef logic [DATA_W-1:0] word_t;

   function automatic word_t neg_f(input word_t v);
      return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic word_t abs_f(input word_t v);
      return v[DATA_W-1] ? neg_f(v) : v;
   endfunction

   function automatic logic is_muldiv_f(input op_e op);
      logic res;
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = 1'b1;
         default:                            res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring radix-2 divider on unsigned magnitudes, one step per cycle.
// quot_o/rem_o show the result of the current step so the last step can be consumed directly.
module muldiv_div_core
   import ex_muldiv_unit_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic              done_o,
   output logic [DATA_W-1:0] quot_o,
   output logic [DATA_W-1:0] rem_o
);

   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_quo;
   logic [DATA_W-1:0] r_dvs;
   logic [CNT_W-1:0]  r_count;
   logic              r_busy;

   logic [DATA_W:0]   w_shift;
   logic [DATA_W-1:0] w_sub;
   logic              w_ge;

   // r_quo shifts the dividend out at the top while quotient bits enter at the bottom
   assign w_shift = {r_rem, r_quo[DATA_W-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dvs});
   assign w_sub   = w_shift[DATA_W-1:0] - r_dvs;

   assign quot_o  = {r_quo[DATA_W-2:0], w_ge};
   assign rem_o   = w_ge ? w_sub : w_shift[DATA_W-1:0];
   assign done_o  = r_busy && (r_count == CNT_W'(DIV_STEPS-1));

   // Divider iteration state: load, step, abort
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rem   <= {DATA_W{1'b0}};
         r_quo   <= {DATA_W{1'b0}};
         r_dvs   <= {DATA_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
         r_busy  <= 1'b0;
      end else if (abort_i) begin
         r_busy  <= 1'b0;
      end else if (start_i) begin
         r_rem   <= {DATA_W{1'b0}};
         r_quo   <= dividend_i;
         r_dvs   <= divisor_i;
         r_count <= {CNT_W{1'b0}};
         r_busy  <= 1'b1;
      end else if (r_busy) begin
         r_rem   <= rem_o;
         r_quo   <= quot_o;
         r_count <= r_count + CNT_W'(1);
         r_busy  <= !done_o;
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Requests a pipeline stall while a multi-cycle MULT/DIV-class op is in flight.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              start_i,
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] src_a_i,
   input  logic [DATA_W-1:0] src_b_i,
   input  logic              flush_i,
   input  logic              ex_hold_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   state_e              r_state;
   logic [DATA_W:0]     r_mul_a;
   logic [DATA_W:0]     r_mul_b;
   logic                r_sign_q;
   logic                r_sign_r;

   op_e                 w_op;
   logic                w_abort;
   logic                w_idle_go;
   logic                w_is_div;
   logic                w_div_start;
   logic                w_div_abort;
   logic                w_div_done;
   logic [DATA_W-1:0]   w_div_a;
   logic [DATA_W-1:0]   w_div_b;
   logic [DATA_W-1:0]   w_quot;
   logic [DATA_W-1:0]   w_rem;
   logic [DATA_W-1:0]   w_quot_fix;
   logic [DATA_W-1:0]   w_rem_fix;
   logic [2*DATA_W-1:0] w_mul_a;
   logic [2*DATA_W-1:0] w_mul_b;
   logic [2*DATA_W-1:0] w_product;

   assign w_op        = op_e'(op_i);
   assign stall_o     = start_i && !flush_i && is_muldiv_f(w_op) && (r_state != ST_DONE);

   // Dropping start_i mid-operation means the instruction was squashed
   assign w_abort     = flush_i || !start_i;
   assign w_idle_go   = (r_state == ST_IDLE) && start_i && !flush_i;
   assign w_is_div    = (w_op == OP_DIV) || (w_op == OP_DIVU);
   assign w_div_start = w_idle_go && w_is_div;
   assign w_div_abort = (r_state == ST_DIV) && w_abort;

   assign w_div_a     = (w_op == OP_DIV) ? abs_f(src_a_i) : src_a_i;
   assign w_div_b     = (w_op == OP_DIV) ? abs_f(src_b_i) : src_b_i;

   // Low 64 bits of the extended operands' product equal the 33x33 signed product
   assign w_mul_a     = {{(DATA_W-1){r_mul_a[DATA_W]}}, r_mul_a};
   assign w_mul_b     = {{(DATA_W-1){r_mul_b[DATA_W]}}, r_mul_b};
   assign w_product   = w_mul_a * w_mul_b;

   assign w_quot_fix  = r_sign_q ? neg_f(w_quot) : w_quot;
   assign w_rem_fix   = r_sign_r ? neg_f(w_rem)  : w_rem;

   muldiv_div_core u_div_core (
      .clk        (clk),
      .resetn     (resetn),
      .start_i    (w_div_start),
      .abort_i    (w_div_abort),
      .dividend_i (w_div_a),
      .divisor_i  (w_div_b),
      .done_o     (w_div_done),
      .quot_o     (w_quot),
      .rem_o      (w_rem)
   );

   // Control FSM plus HI/LO and latched operand/sign state
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= ST_IDLE;
         r_mul_a  <= {(DATA_W+1){1'b0}};
         r_mul_b  <= {(DATA_W+1){1'b0}};
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         hi_o     <= {DATA_W{1'b0}};
         lo_o     <= {DATA_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_idle_go) begin
                  case (w_op)
                     OP_MULT, OP_MULTU: begin
                        r_mul_a <= {(w_op == OP_MULT) & src_a_i[DATA_W-1], src_a_i};
                        r_mul_b <= {(w_op == OP_MULT) & src_b_i[DATA_W-1], src_b_i};
                        r_state <= ST_MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        r_sign_q <= (w_op == OP_DIV) & (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
                        r_sign_r <= (w_op == OP_DIV) & src_a_i[DATA_W-1];
                        r_state  <= ST_DIV;
                     end
                     OP_MTHI: begin
                        if (!ex_hold_i) hi_o <= src_a_i;
                     end
                     OP_MTLO: begin
                        if (!ex_hold_i) lo_o <= src_a_i;
                     end
                     default: r_state <= ST_IDLE;
                  endcase
               end
            end
            ST_MUL: begin
               if (w_abort) begin
                  r_state <= ST_IDLE;
               end else begin
                  hi_o    <= w_product[2*DATA_W-1:DATA_W];
                  lo_o    <= w_product[DATA_W-1:0];
                  r_state <= ST_DONE;
               end
            end
            ST_DIV: begin
               if (w_abort) begin
                  r_state <= ST_IDLE;
               end else if (w_div_done) begin
                  hi_o    <= w_rem_fix;
                  lo_o    <= w_quot_fix;
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_DIV;
               end
            end
            ST_DONE: begin
               if (!flush_i && ex_hold_i) r_state <= ST_DONE;
               else                       r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus randomized ops
// compared against plain-arithmetic HI/LO expectations.
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic        start  = 1'b0;
   logic        flush  = 1'b0;
   logic        hold   = 1'b0;
   logic [2:0]  op     = 3'd0;
   logic [31:0] a      = 32'd0;
   logic [31:0] b      = 32'd0;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   ex_muldiv_unit dut (
      .clk       (clk),
      .resetn    (resetn),
      .start_i   (start),
      .op_i      (op),
      .src_a_i   (a),
      .src_b_i   (b),
      .flush_i   (flush),
      .ex_hold_i (hold),
      .stall_o   (stall),
      .hi_o      (hi),
      .lo_o      (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference {hi,lo} from the arithmetic definition of each op
   function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, p;
      logic [31:0] q, r;
      logic [63:0] res;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q = 32'd0; r = 32'd0; res = 64'd0;
      case (o)
         OP_MULT:  begin p = sx * sy; res = p; end
         OP_MULTU: res = {32'd0, x} * {32'd0, y};
         OP_DIV: begin
            if (y == 32'd0) begin
               q = 32'hFFFF_FFFF;
               r = x[31] ? (~x + 32'd1) : x;
               if (x[31]) begin q = ~q + 32'd1; r = ~r + 32'd1; end
            end else begin
               p = sx / sy; q = p[31:0];
               p = sx % sy; r = p[31:0];
            end
            res = {r, q};
         end
         OP_DIVU: begin
            if (y == 32'd0) begin q = 32'hFFFF_FFFF; r = x; end
            else begin q = x / y; r = x % y; end
            res = {r, q};
         end
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'd0;
         1:       v = 32'hFFFF_FFFF;
         2:       v = 32'h8000_0000;
         3:       v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Issues one op and counts stall cycles; returns with the result visible
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      #1;
      n = 0;
      while (stall && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (o == OP_MTHI || o == OP_MTLO) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
   endtask

   logic [2:0]  t_op [6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIVU, OP_DIV};
   logic [31:0] t_a  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h1234, 32'h8000_0000};
   logic [31:0] t_b  [6] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
   logic [31:0] t_hi [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'h1234, 32'd0};
   logic [31:0] t_lo [6] = '{32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
   int          t_n  [6] = '{2, 2, 33, 33, 33, 33};

   initial begin
      int n;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      logic [63:0] res;

      #3;
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_stall_idle", stall, 1'b0);
      start = 1'b1; op = OP_MULT; #1;
      chk("reset_stall_req", stall, 1'b1);
      start = 1'b0; op = OP_NOP; #1;
      @(negedge clk) resetn = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], n);
         chk($sformatf("dir%0d_stalls", i), n, t_n[i]);
         chk($sformatf("dir%0d_hi", i), hi, t_hi[i]);
         chk($sformatf("dir%0d_lo", i), lo, t_lo[i]);
      end

      // Flush on the 20th divide cycle: HI/LO keep 0 / 0x80000000
      @(negedge clk);
      start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1;
      repeat (19) @(posedge clk);
      #1;
      chk("flush_pre_stall", stall, 1'b1);
      flush = 1'b1; #1;
      chk("flush_stall_now", stall, 1'b0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0; op = OP_NOP; #1;
      chk("flush_after_stall", stall, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      chk("flush_hi_kept", hi, 32'd0);
      chk("flush_lo_kept", lo, 32'h8000_0000);
      run_op(OP_MULT, 32'd5, 32'd6, n);
      chk("post_flush_stalls", n, 2);
      chk("post_flush_hi", hi, 32'd0);
      chk("post_flush_lo", lo, 32'd30);

      // Hold in DONE: no fall back to IDLE, so no new stall with start still high
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'hFFFF_FFFD;
      @(posedge clk); @(posedge clk); #1;
      hold = 1'b1;
      chk("hold_hi", hi, 32'hFFFF_FFFF);
      chk("hold_lo", lo, 32'hFFFF_FFEB);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("hold_stall%0d", i), stall, 1'b0);
      end
      start = 1'b0; hold = 1'b0; op = OP_NOP;
      @(posedge clk); #1;

      // Squash (start low) during MUL cycle: no write
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd2;
      @(posedge clk); #1;
      start = 1'b0; op = OP_NOP;
      @(posedge clk); #1;
      chk("squash_hi", hi, 32'hFFFF_FFFF);
      chk("squash_lo", lo, 32'hFFFF_FFEB);

      // Back-to-back MTHI / MTLO
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; a = 32'h0000_AAAA; #1;
      chk("mthi_stall", stall, 1'b0);
      @(posedge clk); #1;
      chk("mthi_hi", hi, 32'h0000_AAAA);
      op = OP_MTLO; a = 32'h0000_5555; #1;
      chk("mtlo_stall", stall, 1'b0);
      @(posedge clk); #1;
      chk("mtlo_lo", lo, 32'h0000_5555);
      chk("mtlo_hi_kept", hi, 32'h0000_AAAA);
      op = OP_MTHI; a = 32'h0000_DEAD; hold = 1'b1;
      @(posedge clk); #1;
      chk("mthi_hold_blocked", hi, 32'h0000_AAAA);
      op = OP_MTLO; a = 32'h0000_BEEF; hold = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      chk("mtlo_flush_blocked", lo, 32'h0000_5555);
      start = 1'b0; flush = 1'b0; op = OP_NOP;
      m_hi = 32'h0000_AAAA; m_lo = 32'h0000_5555;

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(1, 6));
         ra = pick(); rb = pick();
         run_op(rop, ra, rb, n);
         if (rop == OP_MTHI) m_hi = ra;
         else if (rop == OP_MTLO) m_lo = ra;
         else begin
            res = ref_md(rop, ra, rb);
            m_hi = res[63:32]; m_lo = res[31:0];
         end
         chk($sformatf("rnd%0d_op%0d_stalls", i, rop), n,
             (rop == OP_MTHI || rop == OP_MTLO) ? 0 : ((rop == OP_MULT || rop == OP_MULTU) ? 2 : 33));
         chk($sformatf("rnd%0d_hi a=%h b=%h", i, ra, rb), hi, m_hi);
         chk($sformatf("rnd%0d_lo a=%h b=%h", i, ra, rb), lo, m_lo);
      end

      // Asynchronous reset in the middle of a divide
      @(negedge clk);
      start = 1'b1; op = OP_DIV; a = 32'd12345; b = 32'd7;
      repeat (10) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      start = 1'b0; op = OP_NOP; #1;
      chk("arst_stall", stall, 1'b0);
      @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      run_op(OP_DIVU, 32'd12345, 32'd7, n);
      chk("post_rst_stalls", n, 33);
      chk("post_rst_hi", hi, 32'd4);
      chk("post_rst_lo", lo, 32'd1763);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Execute-stage multiply/divide unit for the main pipeline. It consumes the forwarded operands (rs/rt values after forwarding) of MULT/MULTU/DIV/DIVU/MTHI/MTLO instructions. It owns the architectural HI/LO registers and raises a stall request while a multi-cycle operation is in flight. It sits directly downstream of the forwarding unit and feeds HI/LO to the MFHI/MFLO path.

Parameters:
DATA_W, 32, operand/HI/LO width; only 32 is supported, and the parameter exists for the package typedefs.

Ports:
clk  in  1  clock; all state updates on the rising edge
resetn  in  1  asynchronous, active-low reset
start_i  in  1  EX instruction is a muldiv-class op; held high while the instruction sits in EX
op_i  in  3  operation code (see package): NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO
src_a_i  in  DATA_W  forwarded rs value (dividend / multiplicand / MTHI-MTLO source)
src_b_i  in  DATA_W  forwarded rt value (divisor / multiplier)
flush_i  in  1  exception/flush of the EX instruction; aborts any operation
ex_hold_i  in  1  EX is frozen by a stall from another source this cycle
stall_o  out  1  combinational stall request to the pipeline control
hi_o  out  DATA_W  architectural HI
lo_o  out  DATA_W  architectural LO

Behaviour:
- Reset (resetn=0, async): state=IDLE, hi_o=0, lo_o=0, operand/iteration registers=0. stall_o is then 0 unless start_i is high with a MULT/DIV-class op.
- States: IDLE, MUL, DIV, DONE.
- stall_o = start_i && !flush_i && op_i in {MULT,MULTU,DIV,DIVU} && state!=DONE.
- IDLE + start + MULT/MULTU: latch src_a/src_b, sign-extended (MULT) or zero-extended (MULTU) to 33 bits, then go to MUL.
- MUL (1 cycle): compute the 64-bit product from the latched operands and write {hi,lo}; go to DONE. Total stall is 2 cycles.
- IDLE + start + DIV/DIVU: latch magnitudes (|a|, |b| for DIV; raw values for DIVU), record sign_q = a[31]^b[31] and sign_r = a[31] (DIV only), clear the partial remainder, set count=0, go to DIV.
- DIV: one restoring radix-2 step per cycle, count 0..31. On the count=31 cycle, apply the sign fix (negate q if sign_q, negate r if sign_r), write lo=q and hi=r, and go to DONE. Total stall is 33 cycles.
- Divide by zero: magnitude result is q=0xFFFFFFFF, r=|a|, with the sign fix still applied. No trap is raised.
- Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DONE: stall_o=0 and the new HI/LO are visible. If ex_hold_i=1, stay in DONE with no rewrite. Otherwise go to IDLE.
- IDLE + start + MTHI/MTLO: write hi (or lo) = src_a_i at the clock edge; state stays IDLE; stall_o=0. This write is suppressed if flush_i=1 or ex_hold_i=1.
- flush_i=1 in any state: next state is IDLE and no HI/LO write occurs. This includes the MUL cycle and the count=31 cycle, where the flush overrides the write.
- start_i low while in MUL/DIV (instruction squashed without a flush): the operation is treated as aborted, the same as a flush.
- start_i with op NOP, or start_i=0 in IDLE: no state change.
- No new operation is accepted outside IDLE.

Decomposition:
- Shared package holds the op encoding typedef (3-bit enum: NOP=0, MULT, MULTU, DIV, DIVU, MTHI, MTLO), the state enum, DATA_W, and the DIV_STEPS=32 constant.
- One natural sub-module, muldiv_div_core: the iterative restoring divider datapath (partial remainder, quotient shift, count). It has start/abort/done ports; the parent keeps the FSM, the sign fix and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3: stall_o high for 2 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: after 2 stall cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2: exactly 33 stall cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 gives lo=14, hi=2.
- DIVU by zero with a=0x1234: lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Flush on the 20th DIV cycle: next cycle state=IDLE and stall_o=0; hi/lo keep their pre-divide values. Then a new MULT 5*6 completes with lo=30.
- MTHI 0xAAAA then MTLO 0x5555 on back-to-back cycles: no stall; hi=0xAAAA and lo=0x5555 one edge after each. Assert resetn mid-DIV: hi/lo=0 and stall_o drops immediately (async).
